// File: rtl/dcache_pkg.sv
// Shared constants, FSM state type and line helpers for the data cache
// controller. Optional build macro used by the top: DCACHE_STATS_EN.
package dcache_pkg;

  localparam int ADDR_BITS   = 12;
  localparam int OFFSET_BITS = 4;
  localparam int LINE_BITS   = 128;
  localparam int WORD_BITS   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_MEM  = 2'd2
  } state_t;

  // Pick one 32-bit word out of a 16-byte line (word 0 in the low bits).
  function automatic logic [WORD_BITS-1:0] line_word(input logic [LINE_BITS-1:0] line,
                                                     input logic [1:0]           sel);
    return line[{sel, 5'b00000} +: WORD_BITS];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped storage: valid bits, tags and 16-byte lines. Lookup is
// combinational; a whole line is written on fill, a single word on a store hit.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = ADDR_BITS - OFFSET_BITS - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output logic [LINE_BITS-1:0]  o_rd_line,
  input  logic                  i_fill_en,
  input  logic [INDEX_BITS-1:0] i_fill_index,
  input  logic [TAG_BITS-1:0]   i_fill_tag,
  input  logic [LINE_BITS-1:0]  i_fill_line,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [1:0]            i_wr_word,
  input  logic [WORD_BITS-1:0]  i_wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     r_valid;
  logic [TAG_BITS-1:0]  r_tag  [LINES];
  logic [LINE_BITS-1:0] r_data [LINES];

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_line  = r_data[i_rd_index];

  // Valid bits: cleared by reset, set when a line fill lands.
  always_ff @(posedge clk) begin
    if (reset)          r_valid <= '0;
    else if (i_fill_en) r_valid[i_fill_index] <= 1'b1;
  end

  // Tag/data payload needs no reset; it is ignored until its valid bit is set.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[i_fill_index]  <= i_fill_tag;
      r_data[i_fill_index] <= i_fill_line;
    end else if (i_wr_en) begin
      r_data[i_wr_index][{i_wr_word, 5'b00000} +: WORD_BITS] <= i_wr_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Reads hit in one cycle; misses fetch a full line; every store goes to
// memory and updates the cached word only when the line is resident.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic                 cpu_re,
  input  logic                 cpu_we,
  output logic [31:0]          cpu_rdata,
  output logic                 stall,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic                 hit,
  output logic                 miss,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  localparam int TAG_BITS = ADDR_BITS - OFFSET_BITS - INDEX_BITS;

  state_t                  r_state, w_state_nxt;
  logic                    r_lat_hit;
  logic [ADDR_BITS-1:2]    r_lat_addr;
  logic [31:0]             r_lat_wdata;

  logic [INDEX_BITS-1:0]   w_index;
  logic [TAG_BITS-1:0]     w_tag;
  logic                    w_rd_valid;
  logic [TAG_BITS-1:0]     w_rd_tag;
  logic [LINE_BITS-1:0]    w_rd_line;
  logic                    w_lookup_hit;
  logic                    w_latch;
  logic                    w_fill;
  logic                    w_wr;
  logic                    w_unused;

  assign w_index      = cpu_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_tag        = cpu_addr[ADDR_BITS-1 -: TAG_BITS];
  assign w_lookup_hit = w_rd_valid && (w_rd_tag == w_tag);
  // Byte-within-word bits never matter: accesses are whole words.
  assign w_unused     = &{1'b0, cpu_addr[1:0]};

  dcache_array #(
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk          (clk),
    .reset        (reset),
    .i_rd_index   (w_index),
    .o_rd_valid   (w_rd_valid),
    .o_rd_tag     (w_rd_tag),
    .o_rd_line    (w_rd_line),
    .i_fill_en    (w_fill),
    .i_fill_index (r_lat_addr[OFFSET_BITS +: INDEX_BITS]),
    .i_fill_tag   (r_lat_addr[ADDR_BITS-1 -: TAG_BITS]),
    .i_fill_line  (mem_rdata),
    .i_wr_en      (w_wr),
    .i_wr_index   (r_lat_addr[OFFSET_BITS +: INDEX_BITS]),
    .i_wr_word    (r_lat_addr[3:2]),
    .i_wr_data    (r_lat_wdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Capture the request and its lookup result when leaving IDLE, so the
  // memory transaction stays steady regardless of later lookups.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lat_hit   <= 1'b0;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
    end else if (w_latch) begin
      r_lat_hit   <= w_lookup_hit;
      r_lat_addr  <= cpu_addr[ADDR_BITS-1:2];
      r_lat_wdata <= cpu_wdata;
    end
  end

  // Next state and all controller outputs. Stores take priority over loads.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    hit         = 1'b0;
    miss        = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_rdata   = '0;
    w_latch     = 1'b0;
    w_fill      = 1'b0;
    w_wr        = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_we) begin
          stall       = 1'b1;
          w_latch     = 1'b1;
          w_state_nxt = WR_MEM;
        end else if (cpu_re) begin
          if (w_lookup_hit) begin
            cpu_rdata = line_word(w_rd_line, cpu_addr[3:2]);
          end else begin
            stall       = 1'b1;
            w_latch     = 1'b1;
            w_state_nxt = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        // Stall holds through the fill cycle; the retried lookup returns data.
        stall    = 1'b1;
        mem_re   = 1'b1;
        miss     = 1'b1;
        mem_addr = {r_lat_addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        if (mem_ready) begin
          w_fill      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WR_MEM: begin
        // Release the processor in the completion cycle itself.
        stall     = ~mem_ready;
        mem_we    = 1'b1;
        hit       = r_lat_hit;
        miss      = ~r_lat_hit;
        mem_addr  = {r_lat_addr, 2'b00};
        mem_wdata = r_lat_wdata;
        if (mem_ready) begin
          w_wr        = r_lat_hit;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic        r_refill;
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;
  logic        w_hit_evt;
  logic        w_miss_evt;

  // The lookup right after a fill completes the same miss; do not count it.
  assign w_hit_evt  = ((r_state == IDLE) && !cpu_we && cpu_re && w_lookup_hit && !r_refill) ||
                      ((r_state == WR_MEM) && mem_ready && r_lat_hit);
  assign w_miss_evt = ((r_state == RD_MISS) && mem_ready) ||
                      ((r_state == WR_MEM) && mem_ready && !r_lat_hit);

  // Saturating access counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refill   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_refill <= w_fill;
      if (w_hit_evt && (r_hit_cnt != 16'hFFFF))   r_hit_cnt  <= r_hit_cnt + 16'd1;
      if (w_miss_evt && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed plus randomized bench for dcache_ctrl: a word-addressed memory
// with a fixed 4-edge response, and a reference model that tracks which
// line address each index holds and what memory contains.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [11:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_re, cpu_we;
  logic [31:0]  cpu_rdata;
  logic         stall;
  logic [11:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_we, mem_re, hit, miss;
  logic [127:0] mem_rdata;
  logic         mem_ready = 1'b0;
  logic [2:0]   mcnt = 3'd0;

  logic [31:0]  mem_w   [1024];
  logic [31:0]  ref_mem [1024];
  bit           res_valid [32];
  logic [7:0]   res_line  [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .hit       (hit),
    .miss      (miss),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'd1;
    if (i == 5) return 32'd2;
    if (i == 6) return 32'd3;
    if (i == 7) return 32'd4;
    return (i * 32'h9E3779B9) ^ 32'h5A5A_0000;
  endfunction

  // Memory: strobe held for 4 edges, then a one-cycle ready pulse.
  always @(posedge clk) begin
    if (reset) begin
      mcnt      <= 3'd0;
      mem_ready <= 1'b0;
      for (int i = 0; i < 1024; i++) mem_w[i] <= init_word(i);
    end else if (mem_ready) begin
      mem_ready <= 1'b0;
      mcnt      <= 3'd0;
      if (mem_we) mem_w[mem_addr[11:2]] <= mem_wdata;
    end else if (mem_re || mem_we) begin
      if (mcnt == 3'd3) mem_ready <= 1'b1;
      else              mcnt <= mcnt + 3'd1;
    end
  end

  always_comb begin
    mem_rdata = {mem_w[{mem_addr[11:4], 2'd3}], mem_w[{mem_addr[11:4], 2'd2}],
                 mem_w[{mem_addr[11:4], 2'd1}], mem_w[{mem_addr[11:4], 2'd0}]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) res_valid[i] = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
  endtask

  // One processor access, held until stall drops; checks every memory
  // cycle, the stall length, returned data, then updates the model.
  task automatic access(input bit re, input bit we, input logic [11:0] addr,
                        input logic [31:0] wd, input string tag);
    int   idx      = int'(addr[8:4]);
    bit   lhit     = res_valid[idx] && (res_line[idx] == addr[11:4]);
    bit   is_store = we;
    bit   is_load  = re && !we;
    int   exp_stall = is_store ? 5 : ((is_load && !lhit) ? 6 : 0);
    int   stalls = 0;
    bit   saw_re = 0, saw_we = 0, done = 0;
    logic [31:0] exp_data = ref_mem[addr[11:2]];
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      chk({tag, "_excl"}, {31'b0, mem_re & mem_we}, 32'd0);
      if (mem_re && !saw_re) begin
        saw_re = 1;
        chk({tag, "_rd_addr"}, {20'b0, mem_addr}, {20'b0, addr[11:4], 4'h0});
        chk({tag, "_rd_miss"}, {30'b0, hit, miss}, 32'd1);
      end
      if (mem_we && !saw_we) begin
        saw_we = 1;
        chk({tag, "_wr_addr"}, {20'b0, mem_addr}, {20'b0, addr[11:2], 2'b00});
        chk({tag, "_wr_data"}, mem_wdata, wd);
        chk({tag, "_wr_hitmiss"}, {30'b0, hit, miss}, {30'b0, lhit, !lhit});
      end
      if (stall) stalls++;
      else begin
        done = 1;
        if (is_load) chk({tag, "_rdata"}, cpu_rdata, exp_data);
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $error("FAIL %s_timeout observed=stall_stuck expected=release", tag);
    end
    chk({tag, "_stall_cycles"}, stalls, exp_stall);
    chk({tag, "_saw_mem_re"}, {31'b0, saw_re}, {31'b0, is_load && !lhit});
    chk({tag, "_saw_mem_we"}, {31'b0, saw_we}, {31'b0, is_store});
    if (is_store) ref_mem[addr[11:2]] = wd;
    else if (is_load && !lhit) begin
      res_valid[idx] = 1'b1;
      res_line[idx]  = addr[11:4];
    end
    cpu_re = 0; cpu_we = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; cpu_addr = '0; cpu_wdata = '0; cpu_re = 0; cpu_we = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_strobes", {28'b0, mem_re, mem_we, hit, miss}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    reset = 0;
    @(posedge clk); #1;

    access(1, 0, 12'h010, 32'h0, "rd010_miss");
    access(1, 0, 12'h014, 32'h0, "rd014_hit");
    access(0, 1, 12'h018, 32'hDEADBEEF, "wr018_hit");
    access(1, 0, 12'h018, 32'h0, "rd018_hit");
    access(0, 1, 12'h210, 32'h12345678, "wr210_miss");
    access(1, 0, 12'h210, 32'h0, "rd210_miss");
    access(1, 0, 12'h010, 32'h0, "rd010_remiss");

    // Reset during the third RD_MISS cycle of a miss to 0x410.
    cpu_re = 1; cpu_addr = 12'h410;
    @(negedge clk);
    chk("mid_idle_stall", {31'b0, stall}, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1; cpu_re = 0;
    @(negedge clk);
    chk("mid_rdmiss_re", {31'b0, mem_re}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_after_re", {31'b0, mem_re}, 32'd0);
    chk("mid_after_stall", {31'b0, stall}, 32'd0);
    chk("mid_after_flags", {29'b0, mem_we, hit, miss}, 32'd0);
    reset = 0;
    model_reset();
    @(posedge clk); #1;
    access(1, 0, 12'h010, 32'h0, "post_rst_rd010");

    access(1, 1, 12'h020, 32'hCAFEF00D, "both020");
    access(1, 0, 12'h020, 32'h0, "rd020");

    for (int n = 0; n < 60; n++) begin
      logic [11:0] a;
      int op;
      a  = {3'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      op = $urandom_range(0, 2);
      access(op != 0, op != 1, a, $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 5, number of line-index bits (2**INDEX_BITS lines of 16 bytes); tag width = 12-4-INDEX_BITS.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port cpu_addr  in  12  byte address from the processor.
REQ-005 SHALL have port cpu_wdata  in  32  store data.
REQ-006 SHALL have port cpu_re  in  1  load request.
REQ-007 SHALL have port cpu_we  in  1  store request.
REQ-008 SHALL have port cpu_rdata  out  32  load data, valid when cpu_re=1 and stall=0.
REQ-009 SHALL have port stall  out  1  processor hold; combinational.
REQ-010 SHALL have port mem_addr  out  12  memory address (to DataMem Data_addr).
REQ-011 SHALL have port mem_wdata  out  32  memory store data.
REQ-012 SHALL have ports mem_we and mem_re  out  1 each  memory write and read strobes.
REQ-013 SHALL have ports hit and miss  out  1 each  lookup result qualifying the memory transaction.
REQ-014 SHALL have port mem_rdata  in  128  line returned by memory, byte 0 in bits [7:0].
REQ-015 SHALL have port mem_ready  in  1  one-cycle transaction-complete pulse from memory.

Function
REQ-016 SHALL decode offset=cpu_addr[3:0], index=cpu_addr[4+:INDEX_BITS], tag=remaining upper bits; direct-mapped; write-through, no-write-allocate.
REQ-017 SHALL use FSM states IDLE, RD_MISS, WR_MEM; lookup hit = valid[index] && tag match, evaluated in IDLE.
REQ-018 SHALL on read hit in IDLE: stall=0, cpu_rdata = word at offset[3:2], no memory strobe; cpu_rdata=0 otherwise.
REQ-019 SHALL on read miss: stall=1 same cycle, go to RD_MISS; in RD_MISS drive mem_re=1, miss=1, mem_addr={tag,index,4'h0}, stall=1.
REQ-020 SHALL in RD_MISS on mem_ready=1 write mem_rdata into line, set valid and tag, return to IDLE; the retried lookup then hits.
REQ-021 SHALL on any store (cpu_we=1) go to WR_MEM; there drive mem_we=1, mem_addr={cpu_addr[11:2],2'b00}, mem_wdata=cpu_wdata, hit/miss = lookup result latched in IDLE.
REQ-022 SHALL in WR_MEM on mem_ready=1 update the cached word only if latched hit=1, drop stall combinationally in that cycle, return to IDLE.
REQ-023 SHALL hold mem_re/mem_we and address steady until mem_ready; strobes SHALL be 0 in IDLE; never assert mem_re and mem_we together.
REQ-024 SHALL treat cpu_re=cpu_we=1 as a store (store priority).
REQ-025 SHALL meet latency with a 4-edge memory: read miss stall = 6 cycles, store stall = 5 cycles, read hit stall = 0.

Reset
REQ-026 SHALL on reset: state IDLE, all valid bits 0, mem_we=mem_re=hit=miss=0, latched flags 0; applies mid-transaction, strobes low the following cycle.

Configuration
REQ-027 SHALL, when DCACHE_STATS_EN is defined, add outputs hit_count and miss_count (16 bits each, saturating, reset to 0), incremented once per completed access on lookup result; without the macro these ports and counters SHALL be absent.

Structure
REQ-028 SHALL place ADDR_BITS=12, OFFSET_BITS=4, LINE_BITS=128 and the state enum in package dcache_pkg.
REQ-029 SHALL instantiate one sub-module dcache_array holding valid/tag/data with line-fill and word-write ports.

Verification
REQ-030 SHALL cover: reset, memory line at 0x010 = words {4,3,2,1}, read 0x010 -> mem_re, mem_addr=0x010, stall 6 cycles, cpu_rdata=1.
REQ-031 SHALL cover: then read 0x014 -> hit, stall 0, no mem_re, cpu_rdata=2.
REQ-032 SHALL cover: write 0x018=0xDEADBEEF -> mem_we, hit=1, mem_addr=0x018, stall 5 cycles; read 0x018 hits, returns 0xDEADBEEF.
REQ-033 SHALL cover: write miss 0x210=0x12345678 -> miss=1, no fill; then read 0x210 misses (evicts 0x010 line), returns 0x12345678; read 0x010 misses again.
REQ-034 SHALL cover: reset asserted in 3rd RD_MISS cycle -> mem_re=0 next cycle, stall=0, read 0x010 misses afterwards.
REQ-035 SHALL cover: cpu_re=cpu_we=1 at 0x020 -> store performed, mem_re never asserted.
